alu_ex_stage: RTL and testbench

Execute-stage datapath that consumes the 3-bit ALU operation code produced by ALU_Control and the two register operands. It performs the selected operation and registers the result into the EX/MEM boundary with a valid/ready handshake. Single-cycle ops complete in one cycle. SLL runs as a serial one-bit-per-cycle shifter, so the stage can back-pressure the pipeline.

---
 rtl/alu_ex_stage_if.sv | 37 +++
 rtl/alu_ex_stage.sv | 150 +++++++++++++++
 tb/tb_alu_ex_stage.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ex_stage_if.sv
// Handshake bundle between the ID/EX issue side and the EX/MEM result register of alu_ex_stage.
// The overflow wire only exists when ALU_OVF_EN is defined.
interface alu_ex_stage_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       ALU_control;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [4:0]       shamt;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
`ifdef ALU_OVF_EN
   logic             overflow;
`endif

   // Issue side and result consumer share one bundle: master drives ops and consumes results.
   modport master (
      output in_valid, ALU_control, src_a, src_b, shamt, flush, out_ready,
      input  in_ready, out_valid, result, zero
`ifdef ALU_OVF_EN
      , input overflow
`endif
   );

   modport slave (
      input  in_valid, ALU_control, src_a, src_b, shamt, flush, out_ready,
      output in_ready, out_valid, result, zero
`ifdef ALU_OVF_EN
      , output overflow
`endif
   );
endinterface

// File: rtl/alu_ex_stage.sv
// Execute stage: single-cycle ADD/SUB/AND/OR/SLT plus a serial 1-bit/cycle SLL, registered into EX/MEM.
// Optional feature macro: ALU_OVF_EN adds a registered signed-overflow flag for ADD/SUB.
module alu_ex_stage #(
   parameter int WIDTH = 32
) (
   input  logic                 CLK,
   input  logic                 RST,
   alu_ex_stage_if.slave        bus,
   output logic                 dbg_state
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SLL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state;
   logic [4:0]       count;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             out_valid_q;
`ifdef ALU_OVF_EN
   logic             ovf_q;
   logic             calc_ovf;
`endif

   logic             in_ready_c;
   logic             accept;
   logic             sll_start;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             slt;
   logic [WIDTH-1:0] calc;
   logic [WIDTH-1:0] shifted;

   // Handshake: an op transfers on a rising edge where in_valid && in_ready; a result
   // leaves on an edge where out_valid && out_ready. in_ready only looks at local state,
   // out_ready and flush, never at in_valid, so no combinational loop through upstream.
   assign in_ready_c = (state == IDLE) && (!out_valid_q || bus.out_ready) && !bus.flush;
   assign accept     = bus.in_valid && in_ready_c;
   assign sll_start  = accept && (bus.ALU_control == OP_SLL) && (bus.shamt != 5'd0);
   assign shifted    = {work[WIDTH-2:0], 1'b0};

   always_comb begin
      sum  = bus.src_a + bus.src_b;
      diff = bus.src_a - bus.src_b;
      // Direct signed compare, so a-b overflow cannot corrupt SLT.
      slt  = $signed(bus.src_a) < $signed(bus.src_b);
      calc = '0;
`ifdef ALU_OVF_EN
      calc_ovf = 1'b0;
`endif
      case (bus.ALU_control)
         OP_ADD: begin
            calc = sum;
`ifdef ALU_OVF_EN
            calc_ovf = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
                       (sum[WIDTH-1] != bus.src_a[WIDTH-1]);
`endif
         end
         OP_SUB: begin
            calc = diff;
`ifdef ALU_OVF_EN
            calc_ovf = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
                       (diff[WIDTH-1] != bus.src_a[WIDTH-1]);
`endif
         end
         OP_AND:  calc = bus.src_a & bus.src_b;
         OP_OR:   calc = bus.src_a | bus.src_b;
         OP_SLT:  calc = {{(WIDTH-1){1'b0}}, slt};
         // Only the shamt==0 case lands here; nonzero amounts go through the serial shifter.
         OP_SLL:  calc = bus.src_b;
         default: calc = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         count       <= '0;
         work        <= '0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef ALU_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else if (bus.flush) begin
         // Held result and its flags are left as-is; they are meaningless once invalid.
         state       <= IDLE;
         count       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (sll_start) begin
                  work        <= bus.src_b;
                  count       <= bus.shamt;
                  state       <= SHIFT;
                  out_valid_q <= 1'b0;
               end else if (accept) begin
                  result_q    <= calc;
                  zero_q      <= (calc == '0);
                  out_valid_q <= 1'b1;
`ifdef ALU_OVF_EN
                  ovf_q       <= calc_ovf;
`endif
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            SHIFT: begin
               // Downstream back-pressure never stalls the shift; the slot was freed at accept.
               work  <= shifted;
               count <= count - 5'd1;
               if (count == 5'd1) begin
                  result_q    <= shifted;
                  zero_q      <= (shifted == '0);
                  out_valid_q <= 1'b1;
                  state       <= IDLE;
`ifdef ALU_OVF_EN
                  ovf_q       <= 1'b0;
`endif
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
`ifdef ALU_OVF_EN
   assign bus.overflow  = ovf_q;
`endif
   assign dbg_state     = (state == SHIFT);

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: an abstract result model checked every cycle plus literal spot checks.
// Overflow checks are compiled in only when ALU_OVF_EN is defined.
module tb_alu_ex_stage;
   localparam int W = 32;
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SLL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   logic CLK = 1'b0;
   logic RST;
   logic dbg_state;

   alu_ex_stage_if #(.WIDTH(W)) bus ();

   alu_ex_stage #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] exp_q[$];
   logic         ovf_q[$];
   int           shift_left = 0;
   logic [W-1:0] shift_val;

   function automatic void golden(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [4:0] sh, output logic [W-1:0] r, output logic o);
      longint sa, sb, wide, lim;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lim = longint'(1) <<< (W-1);
      r = '0;
      o = 1'b0;
      case (op)
         OP_ADD: begin wide = sa + sb; r = a + b; o = (wide >= lim) || (wide < -lim); end
         OP_SUB: begin wide = sa - sb; r = a - b; o = (wide >= lim) || (wide < -lim); end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_SLT: r = (sa < sb) ? 1 : 0;
         OP_SLL: r = b << sh;
         default: r = '0;
      endcase
   endfunction

   function automatic logic model_ready();
      return (shift_left == 0) && (exp_q.size() == 0 || bus.out_ready) && !bus.flush;
   endfunction

   always @(posedge CLK) begin
      logic         rdy;
      logic [W-1:0] r;
      logic         o;
      rdy = model_ready();
      if (RST || bus.flush) begin
         exp_q.delete();
         ovf_q.delete();
         shift_left = 0;
      end else if (shift_left > 0) begin
         shift_left--;
         if (shift_left == 0) begin
            exp_q.push_back(shift_val);
            ovf_q.push_back(1'b0);
         end
      end else begin
         if (exp_q.size() != 0 && bus.out_ready) begin
            void'(exp_q.pop_front());
            void'(ovf_q.pop_front());
         end
         if (bus.in_valid && rdy) begin
            golden(bus.ALU_control, bus.src_a, bus.src_b, bus.shamt, r, o);
            if (bus.ALU_control == OP_SLL && bus.shamt != 5'd0) begin
               shift_left = int'(bus.shamt);
               shift_val  = r;
            end else begin
               exp_q.push_back(r);
               ovf_q.push_back(o);
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge CLK) begin
      if (!RST) begin
         check("in_ready", W'(bus.in_ready), W'(model_ready()));
         check("out_valid", W'(bus.out_valid), W'(exp_q.size() != 0));
         check("dbg_state", W'(dbg_state), W'(shift_left != 0));
         if (exp_q.size() != 0) begin
            check("result", bus.result, exp_q[0]);
            check("zero", W'(bus.zero), W'(exp_q[0] == '0));
`ifdef ALU_OVF_EN
            check("overflow", W'(bus.overflow), W'(ovf_q[0]));
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic cyc(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [4:0] sh);
      step();
      bus.in_valid    = v;
      bus.ALU_control = op;
      bus.src_a       = a;
      bus.src_b       = b;
      bus.shamt       = sh;
   endtask

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [4:0]   sh;
      logic [W-1:0] r;
      logic         o;
   } vec_t;

   vec_t vecs[12];

   task automatic run_vec(input vec_t v, input int idx);
      int n;
      cyc(1'b1, v.op, v.a, v.b, v.sh);
      cyc(1'b0, OP_AND, '0, '0, 5'd0);
      n = 0;
      @(negedge CLK);
      while (!bus.out_valid && n < 40) begin
         @(negedge CLK);
         n++;
      end
      check($sformatf("vec%0d_valid", idx), W'(bus.out_valid), W'(1));
      check($sformatf("vec%0d_result", idx), bus.result, v.r);
      check($sformatf("vec%0d_zero", idx), W'(bus.zero), W'(v.r == '0));
`ifdef ALU_OVF_EN
      check($sformatf("vec%0d_ovf", idx), W'(bus.overflow), W'(v.o));
`endif
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      RST = 1'b1;
      bus.in_valid = 1'b0; bus.ALU_control = OP_AND; bus.src_a = '0; bus.src_b = '0;
      bus.shamt = 5'd0; bus.flush = 1'b0; bus.out_ready = 1'b1;
      step();
      step();
      RST = 1'b0;
      @(negedge CLK);
      check("rst_out_valid", W'(bus.out_valid), W'(0));
      check("rst_result", bus.result, 32'h0);
      check("rst_zero", W'(bus.zero), W'(0));
      check("rst_in_ready", W'(bus.in_ready), W'(1));

      // ADD 5+7, one cycle latency
      cyc(1'b1, OP_ADD, 32'd5, 32'd7, 5'd0);
      cyc(1'b0, OP_AND, '0, '0, 5'd0);
      @(negedge CLK);
      check("add_valid", W'(bus.out_valid), W'(1));
      check("add_result", bus.result, 32'd12);
      check("add_zero", W'(bus.zero), W'(0));

      // SUB 9-9 then SLT -1 < 1 back-to-back
      cyc(1'b1, OP_SUB, 32'd9, 32'd9, 5'd0);
      cyc(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
      @(negedge CLK);
      check("sub_result", bus.result, 32'd0);
      check("sub_zero", W'(bus.zero), W'(1));
      check("b2b_in_ready", W'(bus.in_ready), W'(1));
      cyc(1'b1, OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0);
      @(negedge CLK);
      check("slt_neg_result", bus.result, 32'd1);
      check("b2b_in_ready2", W'(bus.in_ready), W'(1));
      cyc(1'b0, OP_AND, '0, '0, 5'd0);
      @(negedge CLK);
      check("slt_ovf_case", bus.result, 32'd0);

      // SLL 3<<4: four busy cycles, result four edges after accept
      cyc(1'b1, OP_SLL, '0, 32'h3, 5'd4);
      cyc(1'b0, OP_AND, '0, '0, 5'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check("sll_busy_ready", W'(bus.in_ready), W'(0));
         check("sll_busy_valid", W'(bus.out_valid), W'(0));
         if (i < 3) step();
      end
      step();
      @(negedge CLK);
      check("sll4_valid", W'(bus.out_valid), W'(1));
      check("sll4_result", bus.result, 32'h30);
      cyc(1'b1, OP_SLL, '0, 32'h3, 5'd0);
      cyc(1'b0, OP_AND, '0, '0, 5'd0);
      @(negedge CLK);
      check("sll0_result", bus.result, 32'h3);

      // OR held under back-pressure, then AND accepted on the consuming edge
      cyc(1'b1, OP_OR, 32'hF0, 32'h0F, 5'd0);
      cyc(1'b1, OP_ADD, 32'd1, 32'd1, 5'd0);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("or_held", bus.result, 32'hFF);
         check("stall_in_ready", W'(bus.in_ready), W'(0));
         step();
      end
      bus.out_ready = 1'b1;
      bus.ALU_control = OP_AND; bus.src_a = 32'hFF; bus.src_b = 32'h3C;
      @(negedge CLK);
      check("consume_in_ready", W'(bus.in_ready), W'(1));
      cyc(1'b0, OP_AND, '0, '0, 5'd0);
      @(negedge CLK);
      check("and_valid", W'(bus.out_valid), W'(1));
      check("and_result", bus.result, 32'h3C);

      // out_ready low does not stall a shift
      cyc(1'b1, OP_SLL, '0, 32'h1, 5'd2);
      cyc(1'b0, OP_AND, '0, '0, 5'd0);
      bus.out_ready = 1'b0;
      step();
      step();
      @(negedge CLK);
      check("sll_noready_result", bus.result, 32'h4);
      bus.out_ready = 1'b1;

      // flush on the second cycle of a long shift
      cyc(1'b1, OP_SLL, '0, 32'h1, 5'd10);
      cyc(1'b0, OP_AND, '0, '0, 5'd0);
      step();
      bus.flush = 1'b1;
      @(negedge CLK);
      check("flush_in_ready", W'(bus.in_ready), W'(0));
      step();
      bus.flush = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         check("flush_no_valid", W'(bus.out_valid), W'(0));
         check("flush_idle", W'(dbg_state), W'(0));
         step();
      end
      cyc(1'b1, OP_ADD, 32'd2, 32'd3, 5'd0);
      cyc(1'b0, OP_AND, '0, '0, 5'd0);
      @(negedge CLK);
      check("post_flush_add", bus.result, 32'd5);

      // reset in the middle of a shift
      cyc(1'b1, OP_SLL, '0, 32'h5, 5'd20);
      cyc(1'b0, OP_AND, '0, '0, 5'd0);
      step();
      RST = 1'b1;
      step();
      RST = 1'b0;
      @(negedge CLK);
      check("rst_mid_valid", W'(bus.out_valid), W'(0));
      check("rst_mid_result", bus.result, 32'h0);
      check("rst_mid_zero", W'(bus.zero), W'(0));
      check("rst_mid_state", W'(dbg_state), W'(0));

      // op table with hand-computed results
      vecs[0]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         1'b0};
      vecs[1]  = '{OP_SUB, 32'h0,         32'h1,         5'd0,  32'hFFFF_FFFF, 1'b0};
      vecs[2]  = '{OP_AND, 32'hA5A5_0F0F, 32'hFF00_FF00, 5'd0,  32'hA500_0F00, 1'b0};
      vecs[3]  = '{OP_OR,  32'h1234_0000, 32'h0000_5678, 5'd0,  32'h1234_5678, 1'b0};
      vecs[4]  = '{OP_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0,  32'h1,         1'b0};
      vecs[5]  = '{OP_SLT, 32'd5,         32'd5,         5'd0,  32'h0,         1'b0};
      vecs[6]  = '{3'b100, 32'd5,         32'd6,         5'd0,  32'h0,         1'b0};
      vecs[7]  = '{3'b101, 32'd5,         32'd6,         5'd0,  32'h0,         1'b0};
      vecs[8]  = '{OP_SLL, 32'h0,         32'h1,         5'd31, 32'h8000_0000, 1'b0};
      vecs[9]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h1,         5'd0,  32'h8000_0000, 1'b1};
      vecs[10] = '{OP_SUB, 32'h8000_0000, 32'h1,         5'd0,  32'h7FFF_FFFF, 1'b1};
      vecs[11] = '{OP_AND, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h8000_0000, 1'b0};
      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      step();
      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
